// File: rtl/tron_ctrl_pkg.sv
// tron_ctrl_pkg: shared encodings and instruction decode for the Tron multicycle controller
package tron_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_LINK, S_JUMP} state_t;
  typedef enum logic [3:0] {ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_MOV, ALU_LSH, ALU_LUI} alu_op_t;
  typedef enum logic [2:0] {K_ALU, K_LOAD, K_STOR, K_JAL, K_BR, K_JC, K_ILL} kind_t;
  typedef struct packed {
    kind_t   kind;
    alu_op_t op;
    logic    imm;
    logic    wr;
    logic    fwe;
  } dec_t;
  localparam logic [3:0] OP_RTYPE = 4'h0, OP_MEMJ = 4'h4, OP_SHIFT = 4'h8, OP_BCOND = 4'hC, OP_LUI = 4'hF;
  localparam logic [3:0] EX_AND = 4'h1, EX_OR = 4'h2, EX_XOR = 4'h3, EX_ADD = 4'h5;
  localparam logic [3:0] EX_SUB = 4'h9, EX_CMP = 4'hB, EX_MOV = 4'hD, EX_LSH = 4'h4;
  localparam logic [3:0] EX_LOAD = 4'h0, EX_STOR = 4'h4, EX_JAL = 4'h8, EX_JCOND = 4'hC;
  localparam logic [1:0] PC_INC = 2'b00, PC_REL = 2'b01, PC_REG = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00, WB_MEM = 2'b01, WB_LINK = 2'b10;
  localparam int FL_C = 0, FL_L = 1, FL_F = 2, FL_Z = 3, FL_N = 4;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF;

  // ALU codes live in ext for R-type and in the opcode for immediate forms
  function automatic dec_t decode(input logic [15:0] ir);
    dec_t d;
    logic [3:0] opc, ext, code;
    opc = ir[15:12];
    ext = ir[7:4];
    code = (opc == OP_RTYPE) ? ext : opc;
    d = '{kind: K_ALU, op: ALU_AND, imm: opc != OP_RTYPE, wr: 1'b1, fwe: 1'b0};
    case (code)
      EX_AND: d.op = ALU_AND;
      EX_OR: d.op = ALU_OR;
      EX_XOR: d.op = ALU_XOR;
      EX_ADD: begin d.op = ALU_ADD; d.fwe = 1'b1; end
      EX_SUB: begin d.op = ALU_SUB; d.fwe = 1'b1; end
      EX_CMP: begin d.op = ALU_SUB; d.fwe = 1'b1; d.wr = 1'b0; end
      EX_MOV: d.op = ALU_MOV;
      default: d.kind = K_ILL;
    endcase
    if (opc == OP_SHIFT) begin
      d.kind = (ext == EX_LSH || ext[3:1] == 3'b000) ? K_ALU : K_ILL;
      d.op = ALU_LSH;
      d.imm = ext != EX_LSH;
    end
    if (opc == OP_LUI) begin
      d.kind = K_ALU;
      d.op = ALU_LUI;
    end
    if (opc == OP_MEMJ)
      d.kind = ext == EX_LOAD ? K_LOAD : ext == EX_STOR ? K_STOR : ext == EX_JAL ? K_JAL :
               ext == EX_JCOND ? K_JC : K_ILL;
    if (opc == OP_BCOND) d.kind = K_BR;
    return d;
  endfunction
endpackage

// File: rtl/tron_cond_eval.sv
// tron_cond_eval: evaluates a branch/jump condition code against the flag register
module tron_cond_eval
  import tron_ctrl_pkg::*;
#(
  parameter int FLAG_W = 5
) (
  input  logic [3:0]        i_cond,
  input  logic [FLAG_W-1:0] i_flags,
  output logic              o_taken
);
  logic w_n, w_z, w_f, w_l, w_c;
  assign w_n = i_flags[FL_N];
  assign w_z = i_flags[FL_Z];
  assign w_f = i_flags[FL_F];
  assign w_l = i_flags[FL_L];
  assign w_c = i_flags[FL_C];
  // one entry per condition code
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      CC_EQ: o_taken = w_z;
      CC_NE: o_taken = !w_z;
      CC_CS: o_taken = w_c;
      CC_CC: o_taken = !w_c;
      CC_HI: o_taken = w_l;
      CC_LS: o_taken = !w_l;
      CC_GT: o_taken = w_n;
      CC_LE: o_taken = !w_n;
      CC_FS: o_taken = w_f;
      CC_FC: o_taken = !w_f;
      CC_LO: o_taken = !w_l && !w_z;
      CC_HS: o_taken = w_l || w_z;
      CC_LT: o_taken = !w_n && !w_z;
      CC_GE: o_taken = w_n || w_z;
      CC_UC: o_taken = 1'b1;
      CC_NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/tron_mc_ctrl.sv
// tron_mc_ctrl: multicycle control FSM with memory handshake watchdog for the Tron CPU
module tron_mc_ctrl
  import tron_ctrl_pkg::*;
#(
  parameter int FLAG_W   = 5,
  parameter int REG_AW   = 4,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_CW  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic [FLAG_W-1:0] flags,
  input  logic              mem_ready,
  output logic              ir_load,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic              mem_req,
  output logic              mem_write,
  output logic              addr_sel,
  output logic              reg_write,
  output logic [1:0]        wb_sel,
  output logic              imm_sel,
  output logic [3:0]        alu_op,
  output logic              flag_we,
  output logic              illegal,
  output logic              bus_err,
  output logic [2:0]        state
);
  state_t r_state, w_next;
  logic [WAIT_CW-1:0] r_wait, w_wait_nx;
  logic [REG_AW-1:0] w_rdest;
  logic w_taken, w_tout, w_alu;
  dec_t w_dec;
  assign w_dec = decode(instr);
  assign w_rdest = instr[8 +: REG_AW];
  assign w_alu = w_dec.kind == K_ALU;
  assign w_tout = (r_state == S_FETCH || r_state == S_MEM) && r_wait == WAIT_CW'(MAX_WAIT);
  assign w_wait_nx = (mem_req && !mem_ready) ? r_wait + 1'b1 : '0;
  assign state = r_state;

  tron_cond_eval #(.FLAG_W(FLAG_W)) u_cond (
    .i_cond (w_rdest),
    .i_flags(flags),
    .o_taken(w_taken)
  );

  // state and wait-state counter; reset abandons any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_wait <= '0;
    end else begin
      r_state <= w_next;
      r_wait <= w_wait_nx;
    end
  end

  // next state and control outputs, all held low while reset is asserted
  always_comb begin
    w_next = r_state;
    ir_load = 1'b0;
    pc_en = 1'b0;
    pc_sel = PC_INC;
    mem_req = 1'b0;
    mem_write = 1'b0;
    addr_sel = 1'b0;
    reg_write = 1'b0;
    wb_sel = WB_ALU;
    imm_sel = 1'b0;
    alu_op = ALU_AND;
    flag_we = 1'b0;
    illegal = 1'b0;
    bus_err = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          bus_err = w_tout;
          mem_req = !w_tout;
          ir_load = !w_tout && mem_ready;
          w_next = ir_load ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          illegal = w_dec.kind == K_ILL;
          pc_en = illegal;
          w_next = illegal ? S_FETCH : (w_dec.kind == K_LOAD || w_dec.kind == K_STOR) ? S_MEM :
                   w_dec.kind == K_JAL ? S_LINK : S_EXEC;
        end
        S_EXEC: begin
          pc_en = 1'b1;
          pc_sel = (w_dec.kind == K_BR && w_taken) ? PC_REL : (w_dec.kind == K_JC && w_taken) ? PC_REG : PC_INC;
          reg_write = w_alu && w_dec.wr;
          flag_we = w_alu && w_dec.fwe;
          imm_sel = w_alu && w_dec.imm;
          alu_op = w_alu ? w_dec.op : ALU_AND;
          w_next = S_FETCH;
        end
        S_MEM: begin
          bus_err = w_tout;
          mem_req = !w_tout;
          addr_sel = !w_tout;
          mem_write = !w_tout && w_dec.kind == K_STOR;
          pc_en = w_tout || (mem_ready && w_dec.kind == K_STOR);
          w_next = w_tout ? S_FETCH : !mem_ready ? S_MEM : w_dec.kind == K_STOR ? S_FETCH : S_WB;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel = WB_MEM;
          pc_en = 1'b1;
          w_next = S_FETCH;
        end
        S_LINK: begin
          reg_write = 1'b1;
          wb_sel = WB_LINK;
          w_next = S_JUMP;
        end
        S_JUMP: begin
          pc_en = 1'b1;
          pc_sel = PC_REG;
          w_next = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_tron_mc_ctrl.sv
// tb_tron_mc_ctrl: randomized instruction stream checked cycle by cycle against a sequence model
module tb_tron_mc_ctrl;
  import tron_ctrl_pkg::*;

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       mem_write;
    logic       addr_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       imm_sel;
    logic [3:0] alu_op;
    logic       flag_we;
    logic       illegal;
    logic       bus_err;
    logic [2:0] state;
  } ov_t;

  localparam int KA = 0, KL = 1, KS = 2, KJ = 3, KB = 4, KC = 5, KI = 6;

  logic clk = 1'b0, reset, mem_ready;
  logic [15:0] instr;
  logic [4:0] flags;
  logic ir_load, pc_en, mem_req, mem_write, addr_sel, reg_write, imm_sel, flag_we, illegal, bus_err;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] alu_op;
  logic [2:0] state;
  ov_t act, exp_o, msk;
  bit exp_v = 1'b0;
  int n_vec = 0, n_bad = 0, n_berr = 0, n_ill = 0, p_ready = 70;
  bit mr_q[$];

  tron_mc_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel), .mem_req(mem_req), .mem_write(mem_write),
    .addr_sel(addr_sel), .reg_write(reg_write), .wb_sel(wb_sel), .imm_sel(imm_sel), .alu_op(alu_op),
    .flag_we(flag_we), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;
  assign act = {ir_load, pc_en, pc_sel, mem_req, mem_write, addr_sel, reg_write, wb_sel, imm_sel,
                alu_op, flag_we, illegal, bus_err, state};

  always @(negedge clk) begin
    if (act.bus_err) n_berr++;
    if (act.illegal) n_ill++;
    if (exp_v) begin
      n_vec++;
      if (((act ^ exp_o) & msk) != '0) begin
        n_bad++;
        $display("FAIL outputs @%0t instr=%h got=%h want=%h mask=%h", $time, instr, act, exp_o, msk);
      end
    end
  end

  task automatic chk(input bit ok, input string nm, input int got, input int want);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
    bit n, z, fl, l, cy;
    {n, z, fl, l, cy} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return l;
      4'h5: return !l;
      4'h6: return n;
      4'h7: return !n;
      4'h8: return fl;
      4'h9: return !fl;
      4'hA: return !l && !z;
      4'hB: return l || z;
      4'hC: return !n && !z;
      4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void alu_code(input logic [3:0] c, output bit ok, output logic [3:0] op, output bit w, output bit f);
    ok = 1; w = 1; f = 0; op = ALU_AND;
    case (c)
      4'h1: op = ALU_AND;
      4'h2: op = ALU_OR;
      4'h3: op = ALU_XOR;
      4'h5: begin op = ALU_ADD; f = 1; end
      4'h9: begin op = ALU_SUB; f = 1; end
      4'hB: begin op = ALU_SUB; f = 1; w = 0; end
      4'hD: op = ALU_MOV;
      default: ok = 0;
    endcase
  endfunction

  function automatic void classify(input logic [15:0] ir, output int k, output logic [3:0] op,
                                   output bit imm, output bit w, output bit f);
    bit ok;
    logic [3:0] o, x;
    o = ir[15:12];
    x = ir[7:4];
    alu_code(o == 4'h0 ? x : o, ok, op, w, f);
    k = ok ? KA : KI;
    imm = o != 4'h0;
    case (o)
      4'h8: begin op = ALU_LSH; w = 1; f = 0; k = (x == 4'h4 || x == 4'h0 || x == 4'h1) ? KA : KI; imm = x != 4'h4; end
      4'hF: begin op = ALU_LUI; w = 1; f = 0; k = KA; imm = 1; end
      4'h4: k = x == 4'h0 ? KL : x == 4'h4 ? KS : x == 4'h8 ? KJ : x == 4'hC ? KC : KI;
      4'hC: k = KB;
      default: ;
    endcase
  endfunction

  function automatic ov_t blank(input state_t s);
    ov_t e;
    e = '0;
    e.state = s;
    return e;
  endfunction

  function automatic ov_t mk_mask(input ov_t e, input bit alu);
    ov_t m;
    m = '1;
    if (!alu) begin m.alu_op = '0; m.imm_sel = 1'b0; end
    if (!e.reg_write) m.wb_sel = '0;
    if (!e.mem_req) m.addr_sel = 1'b0;
    return m;
  endfunction

  task automatic pick(output bit mr);
    if (mr_q.size() > 0) mr = mr_q.pop_front();
    else mr = $urandom_range(0, 99) < p_ready;
  endtask

  task automatic cyc(input ov_t e, input bit alu);
    exp_o = e;
    msk = mk_mask(e, alu);
    exp_v = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // one instruction from FETCH back to FETCH; returns the cycle count
  task automatic run_instr(input logic [15:0] ir, input logic [4:0] fl, output int n);
    int k, w;
    logic [3:0] op;
    bit imm, wr, fw, mr, done, ok;
    ov_t e;
    classify(ir, k, op, imm, wr, fw);
    instr = ir;
    flags = fl;
    n = 0;
    w = 0;
    done = 0;
    while (!done) begin
      pick(mr);
      mem_ready = mr;
      e = blank(S_FETCH);
      if (w == 15) begin e.bus_err = 1; w = 0; end
      else begin e.mem_req = 1; if (mr) begin e.ir_load = 1; done = 1; end else w++; end
      cyc(e, 0);
      n++;
    end
    mem_ready = 1'($urandom_range(0, 1));
    e = blank(S_DECODE);
    if (k == KI) begin e.illegal = 1; e.pc_en = 1; end
    cyc(e, 0);
    n++;
    if (k == KA || k == KB || k == KC) begin
      mem_ready = 1'($urandom_range(0, 1));
      e = blank(S_EXEC);
      e.pc_en = 1;
      if (k == KA) begin e.reg_write = wr; e.flag_we = fw; e.alu_op = op; e.imm_sel = imm; end
      if (k == KB && cond_ok(ir[11:8], fl)) e.pc_sel = 2'b01;
      if (k == KC && cond_ok(ir[11:8], fl)) e.pc_sel = 2'b10;
      cyc(e, k == KA);
      n++;
    end else if (k == KL || k == KS) begin
      w = 0;
      done = 0;
      ok = 0;
      while (!done) begin
        pick(mr);
        mem_ready = mr;
        e = blank(S_MEM);
        if (w == 15) begin e.bus_err = 1; e.pc_en = 1; done = 1; end
        else begin
          e.mem_req = 1;
          e.addr_sel = 1;
          e.mem_write = k == KS;
          if (mr) begin done = 1; ok = 1; e.pc_en = k == KS; end else w++;
        end
        cyc(e, 0);
        n++;
      end
      if (ok && k == KL) begin
        mem_ready = 1'($urandom_range(0, 1));
        e = blank(S_WB);
        e.reg_write = 1; e.wb_sel = 2'b01; e.pc_en = 1;
        cyc(e, 0);
        n++;
      end
    end else if (k == KJ) begin
      e = blank(S_LINK);
      e.reg_write = 1; e.wb_sel = 2'b10;
      cyc(e, 0);
      e = blank(S_JUMP);
      e.pc_en = 1; e.pc_sel = 2'b10;
      cyc(e, 0);
      n += 2;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0: begin r[15:12] = 4'h4; r[7:4] = {2'($urandom_range(0, 3)), 2'b00}; end
      1: r[15:12] = 4'hC;
      2: r[15:12] = 4'h0;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    int n, b0, i0;
    ov_t e;
    reset = 1'b1;
    mem_ready = 1'b0;
    instr = '0;
    flags = '0;
    #2 reset = 1'b0;
    #1 chk(act == '0, "reset_outputs", int'(act), 0);
    repeat (2) @(posedge clk);
    #1 chk(act == '0 && state == S_FETCH, "reset_hold", int'(act), 0);
    reset = 1'b1;
    chk(cond_ok(4'h0, 5'h08) == 1'b1, "model_eq_z", 0, 1);
    chk(cond_ok(4'h0, 5'h00) == 1'b0, "model_eq_nz", 1, 0);
    chk(cond_ok(4'hA, 5'h00) == 1'b1, "model_lo", 0, 1);
    chk(cond_ok(4'hD, 5'h10) == 1'b1, "model_ge", 0, 1);
    mr_q = {1};
    run_instr(16'h0152, 5'h00, n);
    chk(n == 3, "add_cycles", n, 3);
    mr_q = {1, 0, 0, 1};
    run_instr(16'h4100, 5'h00, n);
    chk(n == 6, "load_wait2_cycles", n, 6);
    mr_q = {1};
    run_instr(16'h4182, 5'h00, n);
    chk(n == 4, "jal_cycles", n, 4);
    mr_q = {1, 1};
    run_instr(16'h4043, 5'h00, n);
    chk(n == 3, "stor_cycles", n, 3);
    mr_q = {1};
    run_instr(16'hC005, 5'h08, n);
    mr_q = {1};
    run_instr(16'hC005, 5'h00, n);
    chk(n == 3, "bcond_cycles", n, 3);
    b0 = n_berr;
    mr_q = {};
    repeat (16) mr_q.push_back(0);
    mr_q.push_back(1);
    run_instr(16'h0152, 5'h00, n);
    chk(n == 19, "fetch_timeout_cycles", n, 19);
    chk(n_berr - b0 == 1, "fetch_buserr_pulses", n_berr - b0, 1);
    b0 = n_berr;
    mr_q = {1};
    repeat (16) mr_q.push_back(0);
    run_instr(16'h4100, 5'h00, n);
    chk(n == 18, "mem_timeout_cycles", n, 18);
    chk(n_berr - b0 == 1, "mem_buserr_pulses", n_berr - b0, 1);
    i0 = n_ill;
    mr_q = {1};
    run_instr(16'h7123, 5'h00, n);
    chk(n == 2, "illegal_cycles", n, 2);
    chk(n_ill - i0 == 1, "illegal_pulses", n_ill - i0, 1);
    instr = 16'h4043;
    mem_ready = 1'b1;
    e = blank(S_FETCH); e.mem_req = 1; e.ir_load = 1;
    cyc(e, 0);
    e = blank(S_DECODE);
    cyc(e, 0);
    mem_ready = 1'b0;
    exp_o = blank(S_MEM);
    exp_o.mem_req = 1; exp_o.addr_sel = 1; exp_o.mem_write = 1;
    msk = mk_mask(exp_o, 0);
    @(negedge clk);
    #1;
    exp_v = 1'b0;
    reset = 1'b0;
    #1;
    chk(mem_write == 1'b0, "rst_mid_store_mw", int'(mem_write), 0);
    chk(state == S_FETCH, "rst_mid_store_state", int'(state), int'(S_FETCH));
    chk(act == '0, "rst_mid_store_outputs", int'(act), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (300) begin
      p_ready = ($urandom_range(0, 3) == 0) ? 5 : 70;
      run_instr(rand_instr(), 5'($urandom_range(0, 31)), n);
    end
    exp_v = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tron_mc_ctrl.md
Name: tron_mc_ctrl

Overview:
- Parametrised next-generation multicycle control FSM for the Tron 16-bit CPU. It replaces the fixed-latency controller.
- Decodes the registered instruction (IR) and sequences fetch/decode/execute/memory/writeback.
- New over the previous generation:
  - memory-ready handshake with a wait-state watchdog
  - conditional branch/jump (Bcond/Jcond)
  - illegal-opcode detection
- Sits between the IR/flag register and the datapath muxes, register file, PC and memory port.

Parameters:
- FLAG_W, 5, flag register width; bit order {N,Z,F,L,C} = [4:0].
- REG_AW, 4, register-file address width; Rdest = instr[11:8], Rsrc = instr[3:0].
- MAX_WAIT, 15, maximum cycles mem_req may wait for mem_ready before bus_err.
- WAIT_CW, 4, width of the wait counter; must satisfy 2^WAIT_CW > MAX_WAIT.

Ports:
- clk in 1: system clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- instr in 16: IR contents. Fields: opcode [15:12], Rdest [11:8], ext [7:4], Rsrc [3:0].
- flags in FLAG_W: current flag register.
- mem_ready in 1: memory completes the current request this cycle.
- ir_load out 1: latch fetched word into IR.
- pc_en out 1: update PC.
- pc_sel out 2: 00 PC+1, 01 PC+sext(instr[7:0]), 10 reg[Rsrc].
- mem_req out 1: memory access active.
- mem_write out 1: store strobe (only with mem_req).
- addr_sel out 1: address source; 0 PC, 1 reg[Rsrc].
- reg_write out 1: register-file write enable.
- wb_sel out 2: 00 ALU, 01 memory data, 10 PC+1.
- imm_sel out 1: ALU B operand; 1 immediate, 0 reg[Rsrc].
- alu_op out 4: ALU operation code.
- flag_we out 1: flag register write.
- illegal out 1: one-cycle pulse on undecodable instruction.
- bus_err out 1: one-cycle pulse on memory timeout.
- state out 3: current state (debug).

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, LINK, JUMP.
- Reset (reset=0, asynchronous):
  - state=FETCH and wait counter=0.
  - All outputs 0, except addr_sel=0 and pc_sel=00.
  - Reset mid-access abandons the access; no write completes.
- FETCH:
  - mem_req=1, addr_sel=0.
  - Waits until mem_ready. Then ir_load=1, counter clears, next DECODE.
- DECODE: no side effects. Next state:
  - R/I ALU, shift, LUI, MOVI, CMP/CMPI → EXEC
  - LOAD/STOR → MEM
  - JAL → LINK
  - Bcond/Jcond → EXEC
  - illegal → pulse illegal, pc_en=1 with pc_sel=00, next FETCH
- EXEC: always pc_en=1, next FETCH.
  - ALU ops: reg_write=1, wb_sel=00.
  - CMP/CMPI: reg_write=0; flag_we=1 for CMP, CMPI, ADD(I), SUB(I).
  - Bcond: pc_sel=01 if condition true, else 00.
  - Jcond: pc_sel=10 if condition true, else 00.
- MEM:
  - mem_req=1, addr_sel=1; mem_write=1 for STOR.
  - Holds until mem_ready. Then LOAD → WB; STOR → FETCH with pc_en=1.
- WB (LOAD): reg_write=1, wb_sel=01, pc_en=1, next FETCH.
- LINK (JAL): reg_write=1, wb_sel=10, write PC+1 to Rdest; next JUMP.
- JUMP (JAL): pc_en=1, pc_sel=10, next FETCH.
- Latency with zero wait states:
  - ALU/branch: 3 cycles
  - store: 3 cycles
  - load: 4 cycles
  - JAL: 4 cycles
- Watchdog:
  - The counter increments each cycle mem_req=1 and mem_ready=0.
  - If it reaches MAX_WAIT: pulse bus_err, drop mem_req, clear the counter.
  - Fetch timeout returns to FETCH with PC unchanged (retry).
  - MEM timeout aborts the access with no reg_write or mem_write, then pc_en=1 and next FETCH.
- Condition code = instr[11:8]:
  - EQ 0000 Z; NE 0001 !Z
  - CS 0010 C; CC 0011 !C
  - HI 0100 L; LS 0101 !L
  - GT 0110 N; LE 0111 !N
  - FS 1000 F; FC 1001 !F
  - LO 1010 !L&!Z; HS 1011 L|Z
  - LT 1100 !N&!Z; GE 1101 N|Z
  - UC 1110 always; 1111 never
- Decode map:
  - opcode 0000 R-type, by ext: AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101.
  - The same codes as opcode give the immediate forms: ANDI, ORI, XORI, ADDI, SUBI, CMPI, MOVI.
  - opcode 1000 shifts: ext 0100 LSH; ext 000x LSHI with instr[4] = direction.
  - opcode 1111 LUI.
  - opcode 0100, by ext: 0000 LOAD, 0100 STOR, 1000 JAL, 1100 Jcond.
  - opcode 1100 Bcond.
  - Everything else is illegal.

Decomposition:
- Package tron_ctrl_pkg holds:
  - the state enum
  - opcode/ext constants
  - the alu_op encoding: AND, OR, XOR, ADD, SUB, MOV, LSH, LUI
  - pc_sel and wb_sel encodings
  - condition-code constants
- One combinational sub-module, tron_cond_eval (cond, flags → taken), is shared by Bcond and Jcond.

Test Plan:
- ADD 0x0152, mem_ready tied 1 → ir_load in cycle 1; reg_write=1, wb_sel=00, alu_op=ADD, flag_we=1, pc_en=1 in cycle 3.
- LOAD 0x4100, mem_ready delayed 2 cycles in MEM → mem_req held 3 cycles with addr_sel=1; WB reg_write=1, wb_sel=01; total 6 cycles.
- JAL 0x4182 → LINK has reg_write=1, wb_sel=10; next cycle JUMP has pc_en=1, pc_sel=10.
- Bcond EQ 0xC005 → flags=0x08 gives pc_sel=01; flags=0x00 gives pc_sel=00.
- Fetch with mem_ready held 0 → bus_err pulses after 15 waiting cycles; FETCH restarts and pc_en stays 0.
- Opcode 0x7xxx → illegal pulse in DECODE, pc_en=1; reset=0 during MEM STOR → mem_write drops immediately and state=FETCH.
